alu_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one pipelined 8-bit ALU instance (add/sub/max/min, registered inputs and output, 2-cycle latency) among N_REQ requesters. Accepts at most one operation per cycle over a valid/ready handshake and drives the ALU operand/select bus. Tracks in-flight operations with a tag pipeline matched to the ALU latency, and routes each result back to its originating requester as a one-cycle response pulse. Sits between client engines and the shared ALU datapath.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/alu_rr_scheduler.sv | 122 ++++++++++++
 tb/tb_alu_rr_scheduler.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg
// Shared types and constants for the pipelined 8-bit ALU and the schedulers
// that feed it.
//   alu_op_e : 2-bit operation select as seen on the ALU bus
//   ALU_LAT  : clock edges from operand capture to registered result
//   tag_t    : one in-flight tag stage {valid, requester id}
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_MAX = 2'b01,
    ALU_SUB = 2'b10,
    ALU_MIN = 2'b11
  } alu_op_e;

  localparam int ALU_LAT = 2;

  // Wide enough for the largest supported requester count (8); narrower
  // schedulers zero-extend their index into it.
  localparam int TAG_ID_W = 3;

  typedef struct packed {
    logic                vld;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin arbiter. Grants the first asserted request
// found when searching upward from ptr, wrapping from N-1 back to 0.
//   i_req   : request vector
//   i_ptr   : index that has the highest priority this cycle
//   o_grant : one-hot grant, zero when no request is asserted
//   o_idx   : encoded index of the grant (0 when there is no grant)
//   o_any   : a grant was issued
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic [N-1:0]    o_grant,
  output logic [ID_W-1:0] o_idx,
  output logic            o_any
);

  int cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    cand    = 0;
    for (int off = 0; off < N; off++) begin
      cand = (int'(i_ptr) + off) % N;
      if (!o_any && i_req[cand]) begin
        o_grant[cand] = 1'b1;
        o_idx         = ID_W'(cand);
        o_any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler
// Shares one pipelined ALU among N_REQ requesters. One operation is accepted
// per cycle through a round-robin valid/ready handshake; the granted
// requester's operands are muxed onto the ALU bus, and a tag pipeline that
// matches the ALU latency steers each result back as a one-cycle pulse.
//   i_clk, i_reset : clock, asynchronous active-low reset
//   i_req_valid    : per-requester request valid
//   o_req_ready    : one-hot grant (zero when idle)
//   i_req_a/b/sel  : packed operands/op select, requester k at slice k
//   o_alu_a/b/sel  : operand bus to the ALU (zero when nothing is granted)
//   i_alu_result   : registered ALU result
//   o_rsp_valid    : one-hot response pulse
//   o_rsp_data     : ALU result for the pulsing requester
//   o_busy         : any operation in flight
//   o_op_count     : saturating count of accepted operations
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter int ALU_LAT = alu_pkg::ALU_LAT
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [N_REQ-1:0]      i_req_valid,
  output logic [N_REQ-1:0]      o_req_ready,
  input  logic [N_REQ*DATA_W-1:0] i_req_a,
  input  logic [N_REQ*DATA_W-1:0] i_req_b,
  input  logic [N_REQ*2-1:0]    i_req_sel,
  output logic [DATA_W-1:0]     o_alu_a,
  output logic [DATA_W-1:0]     o_alu_b,
  output logic [1:0]            o_alu_sel,
  input  logic [DATA_W-1:0]     i_alu_result,
  output logic [N_REQ-1:0]      o_rsp_valid,
  output logic [DATA_W-1:0]     o_rsp_data,
  output logic                  o_busy,
  output logic [15:0]           o_op_count
);

  localparam int ID_W = $clog2(N_REQ);

  logic [ID_W-1:0]  ptr_q;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  gnt_idx;
  logic             gnt_any;
  tag_t             tag_q [ALU_LAT];

  rr_arbiter #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .i_req   (i_req_valid),
    .i_ptr   (ptr_q),
    .o_grant (grant),
    .o_idx   (gnt_idx),
    .o_any   (gnt_any)
  );

  // The grant only ever selects a valid requester, so a grant is a transfer.
  assign o_req_ready = grant;

  always_comb begin
    o_alu_a   = '0;
    o_alu_b   = '0;
    o_alu_sel = ALU_ADD;
    if (gnt_any) begin
      o_alu_a   = i_req_a[int'(gnt_idx)*DATA_W +: DATA_W];
      o_alu_b   = i_req_b[int'(gnt_idx)*DATA_W +: DATA_W];
      o_alu_sel = i_req_sel[int'(gnt_idx)*2 +: 2];
    end
  end

  // Priority moves just past the requester that was served.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ptr_q <= '0;
    end else if (gnt_any) begin
      ptr_q <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Tags travel alongside the ALU pipeline so the last stage lines up with
  // i_alu_result; idle cycles inject invalid tags, which is what keeps the
  // ALU's untagged results from producing pulses.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int j = 0; j < ALU_LAT; j++) begin
        tag_q[j] <= '0;
      end
    end else begin
      tag_q[0] <= '{vld: gnt_any, id: TAG_ID_W'(gnt_idx)};
      for (int j = 1; j < ALU_LAT; j++) begin
        tag_q[j] <= tag_q[j-1];
      end
    end
  end

  always_comb begin
    o_rsp_valid = '0;
    for (int k = 0; k < N_REQ; k++) begin
      o_rsp_valid[k] = tag_q[ALU_LAT-1].vld && (tag_q[ALU_LAT-1].id == TAG_ID_W'(k));
    end
  end

  assign o_rsp_data = i_alu_result;

  always_comb begin
    o_busy = 1'b0;
    for (int j = 0; j < ALU_LAT; j++) begin
      o_busy = o_busy | tag_q[j].vld;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_op_count <= '0;
    end else if (gnt_any && (o_op_count != 16'hFFFF)) begin
      o_op_count <= o_op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler
// Self-checking bench for alu_rr_scheduler with a behavioural 2-stage ALU.
// A negedge monitor predicts grants, pushes expected responses into a
// scoreboard and pops them when they fall due; directed checks on grant and
// response logs cover the named scenarios.
module tb_alu_rr_scheduler;
  import alu_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  typedef struct {
    int         due;
    int         id;
    logic [7:0] data;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N*2-1:0] req_sel;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [1:0]     alu_sel;
  logic [W-1:0]   alu_result;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic           busy;
  logic [15:0]    op_count;

  logic [W-1:0]   alu_a_q;
  logic [W-1:0]   alu_b_q;
  logic [1:0]     alu_sel_q;

  int vec_count = 0;
  int miscompares = 0;
  int cyc = 0;
  int mptr = 0;
  logic [15:0] mcount = '0;

  exp_t       sb[$];
  int         grant_log[$];
  int         rsp_id_log[$];
  logic [7:0] rsp_data_log[$];

  always #5 clk = ~clk;

  alu_rr_scheduler #(
    .N_REQ   (N),
    .DATA_W  (W),
    .ALU_LAT (2)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_a      (req_a),
    .i_req_b      (req_b),
    .i_req_sel    (req_sel),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_sel    (alu_sel),
    .i_alu_result (alu_result),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_data   (rsp_data),
    .o_busy       (busy),
    .o_op_count   (op_count)
  );

  function automatic logic [7:0] aluModel(logic [7:0] a, logic [7:0] b, logic [1:0] sel);
    case (sel)
      ALU_ADD: return a + b;
      ALU_MAX: return (a > b) ? a : b;
      ALU_SUB: return a - b;
      default: return (a < b) ? a : b;
    endcase
  endfunction

  // Behavioural shared ALU: registered operands, registered result.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_sel_q  <= '0;
      alu_result <= '0;
    end else begin
      alu_a_q    <= alu_a;
      alu_b_q    <= alu_b;
      alu_sel_q  <= alu_sel;
      alu_result <= aluModel(alu_a_q, alu_b_q, alu_sel_q);
    end
  end

  function automatic logic [N-1:0] modelGrant(logic [N-1:0] v, int p);
    for (int off = 0; off < N; off++) begin
      if (v[(p + off) % N]) return N'(1) << ((p + off) % N);
    end
    return '0;
  endfunction

  function automatic int gAt(int i);
    return (grant_log.size() > i) ? grant_log[i] : -1;
  endfunction

  function automatic int rIdAt(int i);
    return (rsp_id_log.size() > i) ? rsp_id_log[i] : -1;
  endfunction

  function automatic int rDataAt(int i);
    return (rsp_data_log.size() > i) ? int'(rsp_data_log[i]) : -1;
  endfunction

  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    vec_count++;
    if (obs != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic setReq(input int k, input logic [7:0] a, input logic [7:0] b, input alu_op_e sel);
    req_a[k*W +: W]   = a;
    req_b[k*W +: W]   = b;
    req_sel[k*2 +: 2] = sel;
  endtask

  // Called with the bench sitting 1 ns after a rising edge.
  task automatic applyStimulus(input logic [N-1:0] v, input int cycles);
    req_valid = v;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyReset();
    req_valid = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor / scoreboard, sampling away from the active edge.
  initial begin
    logic [N-1:0] eg;
    logic [N-1:0] er;
    logic [7:0]   ed;
    logic         eb;
    int           gi;
    exp_t         e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        sb.delete();
        mptr   = 0;
        mcount = '0;
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_op_count", op_count, 0);
      end else begin
        eb = 1'b0;
        foreach (sb[i]) if (sb[i].due == cyc || sb[i].due == cyc + 1) eb = 1'b1;
        checkOutput("busy", busy, eb);
        er = '0;
        ed = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
          er = N'(1) << sb[0].id;
          ed = sb[0].data;
          void'(sb.pop_front());
        end
        checkOutput("rsp_valid", rsp_valid, er);
        if (er != '0) checkOutput("rsp_data", rsp_data, ed);
        for (int k = 0; k < N; k++) begin
          if (rsp_valid[k]) begin
            rsp_id_log.push_back(k);
            rsp_data_log.push_back(rsp_data);
          end
        end
        checkOutput("op_count", op_count, mcount);
        eg = modelGrant(req_valid, mptr);
        checkOutput("req_ready", req_ready, eg);
        if (eg != '0) begin
          gi = 0;
          for (int k = 0; k < N; k++) if (eg[k]) gi = k;
          grant_log.push_back(gi);
          e.due  = cyc + 2;
          e.id   = gi;
          e.data = aluModel(req_a[gi*W +: W], req_b[gi*W +: W], req_sel[gi*2 +: 2]);
          sb.push_back(e);
          mptr = (gi + 1) % N;
          if (mcount != 16'hFFFF) mcount = mcount + 16'd1;
        end
      end
    end
  end

  initial begin
    int gm;
    int rm;
    int r3_hits;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sel   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single request from r1: add 5 + 3.
    gm = grant_log.size();
    rm = rsp_id_log.size();
    setReq(1, 8'd5, 8'd3, ALU_ADD);
    applyStimulus(4'b0010, 1);
    applyStimulus(4'b0000, 4);
    checkOutput("single_grant", gAt(gm), 1);
    checkOutput("single_rsp_id", rIdAt(rm), 1);
    checkOutput("single_rsp_data", rDataAt(rm), 8);
    checkOutput("single_op_count", op_count, 1);

    // All four requesters, distinct ops, then an idle gap.
    applyReset();
    setReq(0, 8'd10, 8'd20, ALU_ADD);
    setReq(1, 8'd3, 8'd5, ALU_SUB);
    setReq(2, 8'd7, 8'd9, ALU_MAX);
    setReq(3, 8'd7, 8'd9, ALU_MIN);
    gm = grant_log.size();
    rm = rsp_id_log.size();
    applyStimulus(4'b1111, 4);
    applyStimulus(4'b0000, 5);
    for (int i = 0; i < 4; i++) begin
      checkOutput("all4_grant", gAt(gm + i), i);
      checkOutput("all4_rsp_id", rIdAt(rm + i), i);
    end
    checkOutput("all4_rsp_data0", rDataAt(rm), 30);
    checkOutput("all4_rsp_data1", rDataAt(rm + 1), 8'hFE);
    checkOutput("all4_rsp_data2", rDataAt(rm + 2), 9);
    checkOutput("all4_rsp_data3", rDataAt(rm + 3), 7);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_rsp_count", rsp_id_log.size() - rm, 4);

    // Fairness: r0 always valid, r2 joins one cycle later.
    gm = grant_log.size();
    applyStimulus(4'b0001, 1);
    applyStimulus(4'b0101, 5);
    applyStimulus(4'b0000, 4);
    for (int i = 0; i < 6; i++) begin
      checkOutput("fair_grant", gAt(gm + i), (i % 2 == 0) ? 0 : 2);
    end

    // Reset while r3's operation is in flight.
    gm = grant_log.size();
    rm = rsp_id_log.size();
    applyStimulus(4'b1000, 1);
    checkOutput("midrst_grant", gAt(gm), 3);
    applyReset();
    applyStimulus(4'b1010, 1);
    applyStimulus(4'b0000, 4);
    checkOutput("midrst_first_grant", gAt(gm + 1), 1);
    r3_hits = 0;
    for (int i = rm; i < rsp_id_log.size(); i++) if (rsp_id_log[i] == 3) r3_hits++;
    checkOutput("midrst_no_r3_rsp", r3_hits, 0);
    checkOutput("midrst_op_count", op_count, 1);

    // Saturation of the accepted-operation counter.
    applyReset();
    setReq(0, 8'd1, 8'd1, ALU_ADD);
    applyStimulus(4'b0001, 65537);
    applyStimulus(4'b0000, 4);
    checkOutput("sat_op_count", op_count, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
